// File: rtl/mult_div_if.sv
// rtl/mult_div_if.sv - request/result bundle between control unit and mult_div
interface mult_div_if;
    logic        Start;
    logic        Op;
    logic [31:0] A;
    logic [31:0] B;
    logic        Busy;
    logic        Done;
    logic        DivZero;
    logic [31:0] Hi;
    logic [31:0] Lo;

    modport master (
        output Start, Op, A, B,
        input  Busy, Done, DivZero, Hi, Lo
    );

    modport slave (
        input  Start, Op, A, B,
        output Busy, Done, DivZero, Hi, Lo
    );
endinterface

// File: rtl/mult_div.sv
// rtl/mult_div.sv - 32-cycle iterative signed Booth multiply / restoring divide with Hi/Lo
module mult_div (
    input logic       clock,
    input logic       reset,
    mult_div_if.slave bus
);
    typedef enum logic [1:0] {IDLE, RUN, FINISH} state_t;

    state_t      state_q, state_d;
    logic [5:0]  cnt_q, cnt_d;
    logic        op_q, op_d;
    logic        divz_q, divz_d;
    logic        sa_q, sa_d;
    logic        sb_q, sb_d;
    logic [32:0] acc_q, acc_d;
    logic [31:0] mq_q, mq_d;
    logic        qm1_q, qm1_d;
    logic [31:0] m_q, m_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        dz_q, dz_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;

    // Accumulator carries one guard bit so that subtracting -2^31 cannot overflow.
    logic [32:0] booth_addend;
    logic [32:0] booth_sum;
    logic [32:0] rem_shift;
    logic [33:0] rem_diff;
    logic [31:0] abs_a, abs_b;
    logic [31:0] quo_fix, rem_fix;

    assign booth_addend = ({mq_q[0], qm1_q} == 2'b01) ? {m_q[31], m_q} :
                          ({mq_q[0], qm1_q} == 2'b10) ? -{m_q[31], m_q} : 33'd0;
    assign booth_sum    = acc_q + booth_addend;
    assign rem_shift    = {acc_q[31:0], mq_q[31]};
    assign rem_diff     = {1'b0, rem_shift} - {2'b00, m_q};
    assign abs_a        = bus.A[31] ? -bus.A : bus.A;
    assign abs_b        = bus.B[31] ? -bus.B : bus.B;
    assign quo_fix      = (sa_q ^ sb_q) ? -mq_q : mq_q;
    assign rem_fix      = sa_q ? -acc_q[31:0] : acc_q[31:0];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        divz_d  = divz_q;
        sa_d    = sa_q;
        sb_d    = sb_q;
        acc_d   = acc_q;
        mq_d    = mq_q;
        qm1_d   = qm1_q;
        m_d     = m_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        dz_d    = 1'b0;
        hi_d    = hi_q;
        lo_d    = lo_q;
        unique case (state_q)
            IDLE: begin
                if (bus.Start) begin
                    op_d   = bus.Op;
                    sa_d   = bus.A[31];
                    sb_d   = bus.B[31];
                    cnt_d  = 6'd0;
                    acc_d  = 33'd0;
                    qm1_d  = 1'b0;
                    busy_d = 1'b1;
                    if (bus.Op) begin
                        mq_d    = abs_a;
                        m_d     = abs_b;
                        divz_d  = (bus.B == 32'd0);
                        state_d = (bus.B == 32'd0) ? FINISH : RUN;
                    end else begin
                        mq_d    = bus.B;
                        m_d     = bus.A;
                        divz_d  = 1'b0;
                        state_d = RUN;
                    end
                end
            end
            RUN: begin
                cnt_d = cnt_q + 6'd1;
                if (op_q) begin
                    // mq_q shifts out dividend bits at the top and collects quotient bits at the bottom.
                    if (!rem_diff[33]) begin
                        acc_d = rem_diff[32:0];
                        mq_d  = {mq_q[30:0], 1'b1};
                    end else begin
                        acc_d = rem_shift;
                        mq_d  = {mq_q[30:0], 1'b0};
                    end
                end else begin
                    acc_d = {booth_sum[32], booth_sum[32:1]};
                    mq_d  = {booth_sum[0], mq_q[31:1]};
                    qm1_d = mq_q[0];
                end
                if (cnt_q == 6'd31) begin
                    state_d = FINISH;
                end
            end
            FINISH: begin
                busy_d  = 1'b0;
                done_d  = 1'b1;
                state_d = IDLE;
                if (divz_q) begin
                    dz_d = 1'b1;
                end else if (op_q) begin
                    hi_d = rem_fix;
                    lo_d = quo_fix;
                end else begin
                    hi_d = acc_q[31:0];
                    lo_d = mq_q;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= 6'd0;
            op_q    <= 1'b0;
            divz_q  <= 1'b0;
            sa_q    <= 1'b0;
            sb_q    <= 1'b0;
            acc_q   <= 33'd0;
            mq_q    <= 32'd0;
            qm1_q   <= 1'b0;
            m_q     <= 32'd0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            dz_q    <= 1'b0;
            hi_q    <= 32'd0;
            lo_q    <= 32'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            divz_q  <= divz_d;
            sa_q    <= sa_d;
            sb_q    <= sb_d;
            acc_q   <= acc_d;
            mq_q    <= mq_d;
            qm1_q   <= qm1_d;
            m_q     <= m_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            dz_q    <= dz_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    assign bus.Busy    = busy_q;
    assign bus.Done    = done_q;
    assign bus.DivZero = dz_q;
    assign bus.Hi      = hi_q;
    assign bus.Lo      = lo_q;
endmodule

// File: tb/tb_mult_div.sv
// tb/tb_mult_div.sv - directed vector bench for mult_div
module tb_mult_div;
    logic clock = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   errors = 0;

    mult_div_if bus ();

    mult_div dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic        op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dz;
        logic        poke;
    } vec_t;

    vec_t vecs [16];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Caller sits at a negedge; returns at the negedge just after the accepting edge.
    task automatic issue(input logic op, input logic [31:0] a, input logic [31:0] b);
        bus.Start = 1'b1;
        bus.Op    = op;
        bus.A     = a;
        bus.B     = b;
        @(negedge clock);
        bus.Start = 1'b0;
    endtask

    // Returns at the negedge where Done is seen high (or after the cycle budget).
    task automatic await_done(input string name, input int exp_lat, input logic [31:0] exp_hi,
                              input logic [31:0] exp_lo, input logic exp_dz, input logic poke);
        int cyc   = 0;
        int nbusy = 0;
        while (!bus.Done && cyc < 40) begin
            if (bus.Busy) nbusy++;
            if (poke && (cyc == 5 || cyc == 15)) begin
                bus.Start = 1'b1;
                bus.Op    = 1'b1;
                bus.A     = 32'd5;
                bus.B     = 32'd0;
            end else begin
                bus.Start = 1'b0;
            end
            @(negedge clock);
            cyc++;
        end
        bus.Start = 1'b0;
        chk({name, "_latency"}, cyc, exp_lat);
        chk({name, "_busy_cycles"}, nbusy, exp_lat);
        chk({name, "_busy_at_done"}, {31'd0, bus.Busy}, 32'd0);
        chk({name, "_hi"}, bus.Hi, exp_hi);
        chk({name, "_lo"}, bus.Lo, exp_lo);
        chk({name, "_divzero"}, {31'd0, bus.DivZero}, {31'd0, exp_dz});
    endtask

    task automatic check_fall(input string name);
        @(negedge clock);
        chk({name, "_done_fall"}, {31'd0, bus.Done}, 32'd0);
        chk({name, "_dz_fall"}, {31'd0, bus.DivZero}, 32'd0);
    endtask

    initial begin
        int ndone;
        vecs[0]  = '{1'b0, 32'd7,        -32'sd3,      32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0, 1'b0};
        vecs[1]  = '{1'b1, 32'd5,        32'd0,        32'hFFFFFFFF, 32'hFFFFFFEB, 1'b1, 1'b0};
        vecs[2]  = '{1'b0, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0, 1'b1};
        vecs[3]  = '{1'b1, -32'sd7,      32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, 1'b0};
        vecs[4]  = '{1'b1, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0, 1'b0};
        vecs[5]  = '{1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001, 1'b0, 1'b0};
        vecs[6]  = '{1'b0, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'h3FFFFFFF, 32'h00000001, 1'b0, 1'b1};
        vecs[7]  = '{1'b0, 32'h80000000, 32'd1,        32'hFFFFFFFF, 32'h80000000, 1'b0, 1'b0};
        vecs[8]  = '{1'b1, 32'd100,      32'd7,        32'd2,        32'd14,       1'b0, 1'b1};
        vecs[9]  = '{1'b1, 32'd100,      -32'sd7,      32'd2,        32'hFFFFFFF2, 1'b0, 1'b0};
        vecs[10] = '{1'b1, -32'sd100,    -32'sd7,      32'hFFFFFFFE, 32'd14,       1'b0, 1'b0};
        vecs[11] = '{1'b1, 32'd7,        32'd100,      32'd7,        32'd0,        1'b0, 1'b0};
        vecs[12] = '{1'b1, 32'h7FFFFFFF, 32'h80000000, 32'h7FFFFFFF, 32'd0,        1'b0, 1'b0};
        vecs[13] = '{1'b1, 32'h80000000, 32'h80000000, 32'd0,        32'd1,        1'b0, 1'b0};
        vecs[14] = '{1'b1, -32'sd9,      32'd0,        32'd0,        32'd1,        1'b1, 1'b0};
        vecs[15] = '{1'b0, -32'sd6,      32'd5,        32'hFFFFFFFF, 32'hFFFFFFE2, 1'b0, 1'b0};

        bus.Start = 1'b0;
        bus.Op    = 1'b0;
        bus.A     = 32'd0;
        bus.B     = 32'd0;
        repeat (3) @(negedge clock);
        chk("rst_busy", {31'd0, bus.Busy}, 32'd0);
        chk("rst_done", {31'd0, bus.Done}, 32'd0);
        chk("rst_dz", {31'd0, bus.DivZero}, 32'd0);
        chk("rst_hi", bus.Hi, 32'd0);
        chk("rst_lo", bus.Lo, 32'd0);
        reset = 1'b0;
        @(negedge clock);

        for (int i = 0; i < 16; i++) begin
            issue(vecs[i].op, vecs[i].a, vecs[i].b);
            await_done($sformatf("vec%0d", i), vecs[i].dz ? 1 : 33, vecs[i].hi, vecs[i].lo,
                       vecs[i].dz, vecs[i].poke);
            check_fall($sformatf("vec%0d", i));
        end

        // Back-to-back: new Start in the Done cycle is accepted.
        issue(1'b0, 32'd7, -32'sd3);
        await_done("b2b_first", 33, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0, 1'b0);
        issue(1'b1, -32'sd7, 32'd2);
        await_done("b2b_second", 33, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, 1'b0);
        check_fall("b2b_second");

        // Reset ten cycles into a DIV discards the work and clears Hi/Lo.
        issue(1'b1, 32'd100, 32'd7);
        repeat (9) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        chk("midrst_busy", {31'd0, bus.Busy}, 32'd0);
        chk("midrst_hi", bus.Hi, 32'd0);
        chk("midrst_lo", bus.Lo, 32'd0);
        chk("midrst_done", {31'd0, bus.Done}, 32'd0);
        ndone = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clock);
            if (bus.Done) ndone++;
        end
        chk("midrst_no_done", ndone, 0);
        issue(1'b0, 32'd3, 32'd4);
        await_done("post_rst_mult", 33, 32'd0, 32'd12, 1'b0, 1'b0);
        check_fall("post_rst_mult");

        // Reset wins over a simultaneous Start.
        reset     = 1'b1;
        bus.Start = 1'b1;
        bus.Op    = 1'b0;
        bus.A     = 32'd2;
        bus.B     = 32'd2;
        @(negedge clock);
        reset     = 1'b0;
        bus.Start = 1'b0;
        chk("rst_prio_busy", {31'd0, bus.Busy}, 32'd0);
        @(negedge clock);
        chk("rst_prio_busy2", {31'd0, bus.Busy}, 32'd0);
        chk("rst_prio_lo", bus.Lo, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
